clock_switch_controller: RTL and testbench

CLOCK_SWITCH_CONTROLLER -- requirements
Module: clock_switch_controller

---
 rtl/clock_switch_controller.sv | 123 ++++++++++++
 tb/tb_clock_switch_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_switch_controller.sv
// Glitch-free clock source switch sequencer: gates every source, moves the mux
// select while all sources are quiet, then ungates only the newly selected one.
module clock_switch_controller #(
  parameter int NUM_CLOCKS  = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int RESET_SEL   = 0,
  localparam int SEL_W = (NUM_CLOCKS > 2) ? $clog2(NUM_CLOCKS) : 1,
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SEL_W-1:0]      req_sel,
  output logic [SEL_W-1:0]      mux_sel,
  output logic [NUM_CLOCKS-1:0] gate,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OLD = 2'd1,
    SWITCH   = 2'd2,
    UNGATE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]      HOLD        = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  localparam logic [SEL_W-1:0]      RESET_SEL_V = SEL_W'(RESET_SEL);
  localparam logic [SEL_W:0]        NUM_SEL     = (SEL_W + 1)'(NUM_CLOCKS);
  localparam logic [NUM_CLOCKS-1:0] ONE_HOT     = NUM_CLOCKS'(1);
  localparam logic [NUM_CLOCKS-1:0] RESET_GATE  = ~(ONE_HOT << RESET_SEL);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [SEL_W-1:0]        mux_q, mux_d;
  logic [NUM_CLOCKS-1:0]   gate_q, gate_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= RESET_SEL_V;
      mux_q   <= RESET_SEL_V;
      gate_q  <= RESET_GATE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      mux_q   <= mux_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    mux_d   = mux_q;
    gate_d  = gate_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if ({1'b0, req_sel} >= NUM_SEL) begin
            err_d = 1'b1;
          end else if (req_sel == mux_q) begin
            done_d = 1'b1;
          end else begin
            sel_d   = req_sel;
            gate_d  = '1;
            cnt_d   = HOLD;
            state_d = GATE_OLD;
          end
        end
      end
      GATE_OLD: begin
        // Mux select only moves here, when every source is held quiet.
        if (cnt_q <= CNT_ONE) begin
          mux_d   = sel_q;
          cnt_d   = HOLD;
          state_d = SWITCH;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SWITCH: begin
        if (cnt_q <= CNT_ONE) begin
          gate_d  = ~(ONE_HOT << sel_q);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = UNGATE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      UNGATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mux_sel   = mux_q;
  assign gate      = gate_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_clock_switch_controller.sv
// Bench for clock_switch_controller (3 sources, 3 hold cycles): directed
// scenarios followed by random requests, checked against a timeline model.
module tb_clock_switch_controller;

  localparam int NC = 3;
  localparam int H  = 3;
  localparam int W  = 17;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_sel;
  logic [1:0]    mux_sel;
  logic [NC-1:0] gate;
  logic          busy;
  logic          done;
  logic          err;

  clock_switch_controller #(
    .NUM_CLOCKS (NC),
    .HOLD_CYCLES(H),
    .RESET_SEL  (0)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sel  (req_sel),
    .mux_sel  (mux_sel),
    .gate     (gate),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // ---------------- clock / reset / cycle count ----------------
  int cyc;
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc <= cyc + 1;
    end
  end

  // ---------------- reference model ----------------
  // Settled selection plus at most one in-flight switch, described as a
  // timeline: H cycles all gated on the old select, H cycles all gated on the
  // new select, then the new source ungated (done cycle, still busy).
  int cur_sel;
  bit sw_active;
  int sw_start;
  int sw_new;
  int idle_from;

  logic [W-1:0] exp_q[$];   // {is_err, cycle[15:0]}

  int n_vec;
  int n_miss;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_at(input int c, output int m, output int g, output bit b);
    if (sw_active && c >= sw_start) begin
      if (c < sw_start + H) begin
        m = cur_sel; g = 7; b = 1'b1;
      end else if (c < sw_start + 2 * H) begin
        m = sw_new;  g = 7; b = 1'b1;
      end else begin
        m = sw_new;  g = 7 & ~(1 << sw_new); b = (c == sw_start + 2 * H);
      end
    end else begin
      m = cur_sel; g = 7 & ~(1 << cur_sel); b = 1'b0;
    end
  endfunction

  function automatic void model_accept(input int sel, input int c);
    if (sw_active) begin
      cur_sel   = sw_new;
      sw_active = 1'b0;
    end
    if (sel >= NC) begin
      exp_q.push_back({1'b1, 16'(c)});
    end else if (sel == cur_sel) begin
      exp_q.push_back({1'b0, 16'(c)});
    end else begin
      sw_active = 1'b1;
      sw_start  = c;
      sw_new    = sel;
      idle_from = c + 2 * H + 1;
      exp_q.push_back({1'b0, 16'(c + 2 * H)});
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    cur_sel   = 0;
    sw_active = 1'b0;
    sw_start  = 0;
    sw_new    = 0;
    idle_from = 0;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int m;
    int g;
    bit b;
    logic [W-1:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        model_at(cyc, m, g, b);
        chk("mux_sel", int'(mux_sel), m);
        chk("gate", int'(gate), g);
        chk("busy", int'(busy), int'(b));
        chk("req_ready", int'(req_ready), int'(!b));
        chk("done_err_excl", int'(done && err), 0);
        while (exp_q.size() > 0 && int'(exp_q[0][15:0]) < cyc) begin
          e = exp_q.pop_front();
          n_vec++;
          n_miss++;
          $display("FAIL pulse_missing: got none expected %s at cycle %0d",
                   e[16] ? "err" : "done", int'(e[15:0]));
        end
        if (done || err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", int'({done, err}), 0);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_cycle", cyc, int'(e[15:0]));
            chk("pulse_is_err", int'(err), int'(e[16]));
            chk("pulse_is_done", int'(done), int'(!e[16]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Holds the request until the model says the controller is idle; with junk
  // set, valid/sel toggle randomly while busy and must be ignored.
  task automatic do_req(input int sel, input bit junk);
    int waits;
    waits = 0;
    forever begin
      @(negedge clock);
      if (cyc >= idle_from) begin
        req_valid = 1'b1;
        req_sel   = 2'(sel);
        @(posedge clock);
        #1;
        model_accept(sel, cyc);
        req_valid = 1'b0;
        return;
      end
      if (junk) begin
        req_valid = 1'($urandom_range(0, 1));
        req_sel   = 2'($urandom_range(0, 3));
      end else begin
        req_valid = 1'b1;
        req_sel   = 2'(sel);
      end
      waits++;
      if (waits > 100) begin
        chk("accept_timeout", waits, 0);
        req_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      req_valid = 1'b0;
      req_sel   = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mux_sel"}, int'(mux_sel), 0);
    chk({tag, "_gate"}, int'(gate), 6);
    chk({tag, "_req_ready"}, int'(req_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec     = 0;
    n_miss    = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_sel   = 2'd0;
    model_reset();
    #1;
    check_reset_values("rst");
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    do_req(0, 1'b0);              // same source -> done next cycle
    idle_cycles(1);
    do_req(3, 1'b0);              // out of range -> err next cycle
    idle_cycles(1);
    do_req(2, 1'b0);              // full switch 0 -> 2
    do_req(1, 1'b0);              // held while busy, accepted when idle
    idle_cycles(2 * H + 3);

    // Reset in the middle of a switch: mux has just moved, gates all closed.
    do_req(2, 1'b0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_reset_values("midrst");
    @(posedge clock);
    #2 reset = 1'b0;
    idle_cycles(2 * H + 3);

    for (int i = 0; i < 40; i++) begin
      do_req(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(2 * H + 4);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
